// File: rtl/imem_flash_loader_pkg.sv
// Shared types and helpers for the instruction-memory flash loader.
// Optional build macro used by the loader: IMEM_FLASH_CHECKSUM_EN.
package imem_flash_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    // Wide enough for any flash port width this loader is built with.
    localparam int ADDR_MAX_W = 64;

    // Byte address to word index.
    function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr);
        return addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/imem_flash_loader_release_timer.sv
// Down-counter that times the core reset hold-off after a load session.
module loader_release_timer
    import imem_flash_loader_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    // Load on session end, then count down to zero and hold there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/imem_flash_loader.sv
// Flash-port loader for the instruction RAM: addressed or auto-increment
// writes, sticky address error, word count, timed core release and reload
// from RUN. Optional macro IMEM_FLASH_CHECKSUM_EN adds a session checksum
// compared against expected_sum at flash_done.
module imem_flash_loader
    import imem_flash_loader_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH_WORDS    = 256,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flash_en,
    input  logic [WIDTH-1:0]               flash_addr,
    input  logic [WIDTH-1:0]               flash_data,
    input  logic                           flash_mode,
    input  logic                           flash_done,
    output logic                           flash_ready,
    output logic                           flash_err,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [WIDTH-1:0]               mem_wdata,
    output logic                           core_rst,
    output logic [$clog2(DEPTH_WORDS):0]   load_count
`ifdef IMEM_FLASH_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]               checksum,
    input  logic [WIDTH-1:0]               expected_sum
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int TW = $clog2(RELEASE_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_LOAD    = 2'(LOAD);
    localparam logic [1:0] ST_RELEASE = 2'(RELEASE);
    localparam logic [1:0] ST_RUN     = 2'(RUN);

    logic [1:0]            state, state_next;
    logic [AW:0]           ptr, ptr_base, ptr_next;
    logic [AW:0]           cnt_base, cnt_next;
    logic                  err_base, err_next;
    logic [ADDR_MAX_W-1:0] idx;
    logic                  session_start, wr_act, wr_ok, done_taken, sum_bad;
    logic                  timer_load, timer_expired;

`ifdef IMEM_FLASH_CHECKSUM_EN
    logic [WIDTH-1:0]      sum_base, sum_next;

    // A session ends on a bad checksum only when flash_done is honoured.
    always_comb begin
        sum_base = session_start ? '0 : checksum;
        sum_next = sum_base + (wr_ok ? flash_data : '0);
        sum_bad  = done_taken && (sum_next != expected_sum);
    end

    // Running sum of accepted words, cleared when a new session starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else begin
            checksum <= sum_next;
        end
    end
`else
    assign sum_bad = 1'b0;
`endif

    // Write qualification: a write in IDLE or RUN opens a fresh session, so
    // counters, pointer and error flag are taken as cleared for that write.
    always_comb begin
        session_start = flash_en && ((state == ST_IDLE) || (state == ST_RUN));
        wr_act        = flash_en && (state != ST_RELEASE);
        cnt_base      = session_start ? '0 : load_count;
        ptr_base      = session_start ? '0 : ptr;
        err_base      = session_start ? 1'b0 : flash_err;
        idx           = flash_mode ? ADDR_MAX_W'(ptr_base)
                                   : word_index(ADDR_MAX_W'(flash_addr));
        wr_ok         = wr_act && (flash_mode || (flash_addr[1:0] == 2'b00))
                        && (idx < ADDR_MAX_W'(DEPTH_WORDS));
        cnt_next      = (wr_ok && (cnt_base != (AW+1)'(DEPTH_WORDS))) ? cnt_base + 1'b1 : cnt_base;
        ptr_next      = wr_ok ? (AW+1)'(idx + 1) : ptr_base;
        err_next      = err_base | (wr_act && !wr_ok);
        done_taken    = flash_done && ((state == ST_IDLE) || (state == ST_LOAD)
                                       || ((state == ST_RUN) && flash_en));
    end

    // Next state: a same-cycle write is absorbed before flash_done ends the session.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        case (state)
            ST_RELEASE: begin
                if (timer_expired) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                if (wr_act) begin
                    state_next = ST_LOAD;
                end
                if (done_taken) begin
                    if (sum_bad) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RELEASE;
                        timer_load = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and registered RAM write port / session bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_count <= '0;
            ptr        <= '0;
            flash_err  <= 1'b0;
        end else begin
            state      <= state_next;
            mem_we     <= wr_ok;
            if (wr_ok) begin
                mem_addr  <= idx[AW-1:0];
                mem_wdata <= flash_data;
            end
            load_count <= cnt_next;
            ptr        <= ptr_next;
            flash_err  <= err_next | sum_bad;
        end
    end

    loader_release_timer #(
        .W(TW)
    ) u_release_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (TW'(RELEASE_CYCLES - 1)),
        .enable     (state == ST_RELEASE),
        .expired    (timer_expired)
    );

    assign core_rst    = (state != ST_RUN);
    assign flash_ready = (state != ST_RELEASE);

endmodule
